cpu_prog_feeder: RTL
====================

Name: cpu_prog_feeder

Overview:
Initiator-side driver for the cpu block's instruction interface (in/load/s/w/out/N/V/Z).
- Holds a small writable program memory and presents one instruction at a time on cpu_in.
- Pulses cpu_load, starts each instruction with cpu_s, waits for completion on cpu_w, then captures cpu_out and the flags.
- Sits between bench/host logic and cpu; replaces hand-timed stimulus with a handshaked sequencer.

Parameters:
DEPTH, 16, program memory entries (power of 2)
AW, 4, program address width, log2(DEPTH)
TIMEOUT_CYC, 64, max cycles spent waiting on cpu_w in any one state before abort

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
prog_we  input  1  program memory write enable; ignored while busy=1
prog_addr  input  AW  program write address
prog_wdata  input  16  instruction word to write
go  input  1  start-sequence strobe; sampled only in IDLE
n_instr  input  AW+1  number of instructions to run, 0..DEPTH
cpu_in  output  16  instruction to cpu (registered)
cpu_load  output  1  cpu instruction-register load enable
cpu_s  output  1  cpu start
cpu_w  input  1  cpu waiting (idle) flag
cpu_out  input  16  cpu datapath result
cpu_N  input  1  cpu negative flag
cpu_V  input  1  cpu overflow flag
cpu_Z  input  1  cpu zero flag
busy  output  1  sequence in progress
done  output  1  one-cycle pulse at normal sequence completion
timeout  output  1  sticky watchdog abort flag
pc  output  AW  index of current instruction
last_out  output  16  cpu_out captured after the most recent completed instruction
last_flags  output  3  {N,V,Z} captured with last_out

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; memory contents undefined and not cleared.
- Memory write: synchronous, in IDLE only.
- IDLE: busy=0.
  - go=1 and n_instr!=0: pc<=0, clear timeout, go to LOAD.
  - go=1 and n_instr==0: clear timeout, go to FINISH; no cpu activity.
- LOAD: cpu_in<=mem[pc], cpu_load=1 for exactly this one cycle, then STROBE. cpu_in is held stable until the next LOAD.
- STROBE: wait for cpu_w=1, then drive cpu_s<=1 and go to ACK.
- ACK: hold cpu_s=1 until cpu_w=0 is sampled, then cpu_s<=0 and go to RUN. cpu_s therefore drops one edge after the cpu leaves its wait state, which prevents re-execution.
- RUN: wait for cpu_w=1, then CAPTURE.
- CAPTURE (1 cycle):
  - last_out<=cpu_out; last_flags<={cpu_N,cpu_V,cpu_Z}.
  - If pc+1==n_instr go to FINISH, else pc<=pc+1 and LOAD.
- FINISH: done=1 for one cycle, then IDLE. busy=1 in every state except IDLE.
- Watchdog:
  - Counter clears on every state change.
  - In STROBE/ACK/RUN, if the counter reaches TIMEOUT_CYC: timeout<=1, cpu_s<=0, go to IDLE, no done pulse.
  - timeout stays set until the next accepted go.
- cpu_load is 0 in every state except LOAD.
- n_instr>DEPTH: saturates to DEPTH.
- pc wraps never; maximum pc is DEPTH-1.
- Simultaneous events: go while busy is ignored; prog_we while busy is ignored.
- Reset mid-sequence: immediate abort, with cpu_s and cpu_load forced to 0 asynchronously.

Optional Feature:
Macro FEEDER_CHECK_EN.
- Defined:
  - Adds a second DEPTH x 16 expected-result memory, written via inputs exp_we/exp_wdata (address is prog_addr).
  - Adds a sticky output mismatch and an output mismatch_pc[AW-1:0].
  - In CAPTURE, if cpu_out != exp[pc] and mismatch=0: mismatch<=1 and mismatch_pc<=pc.
  - mismatch clears on accepted go.
  - The sequence continues after a mismatch.
- Undefined: these ports and the second memory do not exist; behaviour is otherwise identical.

Test Plan:
1. Load 0xD004 (mov r0,#4) and 0xC020 (mov r1,r0), n_instr=2, go, connected to cpu -> done pulses once; last_out=0x0004; pc=1; busy low afterwards; cpu_load high exactly 2 cycles total.
2. Program {0xD004, 0xC020, 0xD273, 0xA269} (mov r2,#115; add r3,r2,r1 LSL#1) -> last_out=0x007B (123).
3. Append 0xA801 (cmp r0,r1), n_instr=5 -> last_flags={N=0,V=0,Z=1}. Replace it with 0xA809 (cmp r0,r1 LSL#1) -> N=1.
4. cpu stub holds cpu_w=0 forever, go -> timeout=1 after TIMEOUT_CYC cycles in STROBE; no done; cpu_s=0. Next go clears timeout.
5. Assert reset during RUN -> cpu_s=0, cpu_load=0, busy=0 in the same cycle. go with n_instr=0 -> done after 2 cycles, no cpu_load.
6. With FEEDER_CHECK_EN, expect 0x007C at pc=3 for the program in scenario 2 -> mismatch=1, mismatch_pc=3, done still pulses.

Source files
------------

// File: rtl/cpu_prog_feeder.sv
// cpu_prog_feeder
// ---------------
// Initiator-side sequencer for the cpu instruction interface. A host fills a
// small program memory while the feeder is idle, then strobes go. The feeder
// presents each instruction on cpu_in, pulses cpu_load, starts the cpu with a
// cpu_s handshake, waits for the cpu to return to its wait state and captures
// cpu_out and the {N,V,Z} flags. A watchdog aborts the sequence if the cpu
// stops answering.
//
// Optional feature (macro FEEDER_CHECK_EN): a second memory of expected
// results is compared against cpu_out after each instruction; the first
// difference is latched into mismatch / mismatch_pc.
//
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   prog_we/prog_addr/prog_wdata  program memory write port (idle only)
//   go, n_instr                start strobe and instruction count (0..DEPTH)
//   cpu_in, cpu_load, cpu_s    instruction, load enable and start to the cpu
//   cpu_w, cpu_out, cpu_N/V/Z  cpu wait flag, result and status flags
//   busy, done, timeout        sequence status (timeout is sticky)
//   pc                         index of the current instruction
//   last_out, last_flags       most recent captured result and {N,V,Z}
//   exp_we, exp_wdata          expected-result write (FEEDER_CHECK_EN only)
//   mismatch, mismatch_pc      first-difference report (FEEDER_CHECK_EN only)

module cpu_prog_feeder #(
   parameter int DEPTH       = 16,
   parameter int AW          = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [15:0]   prog_wdata,
   input  logic          go,
   input  logic [AW:0]   n_instr,
   output logic [15:0]   cpu_in,
   output logic          cpu_load,
   output logic          cpu_s,
   input  logic          cpu_w,
   input  logic [15:0]   cpu_out,
   input  logic          cpu_N,
   input  logic          cpu_V,
   input  logic          cpu_Z,
   output logic          busy,
   output logic          done,
   output logic          timeout,
   output logic [AW-1:0] pc,
   output logic [15:0]   last_out,
   output logic [2:0]    last_flags
`ifdef FEEDER_CHECK_EN
   ,
   input  logic          exp_we,
   input  logic [15:0]   exp_wdata,
   output logic          mismatch,
   output logic [AW-1:0] mismatch_pc
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_STROBE,
      S_ACK,
      S_RUN,
      S_CAPTURE,
      S_FINISH
   } state_t;

   localparam int WDW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [AW:0]    DEPTH_N = (AW+1)'(DEPTH);
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);

   state_t          state;
   state_t          state_nx;
   logic [15:0]     mem [DEPTH];
   logic [WDW-1:0]  wdog;
   logic [AW:0]     n_lat;
   logic [AW:0]     n_sat;
   logic [AW-1:0]   pc_inc;
   logic            wd_expired;
   logic            last_instr;
   logic            wd_abort;

   // Counts above DEPTH are clamped so pc can never run past the memory.
   assign n_sat      = (n_instr > DEPTH_N) ? DEPTH_N : n_instr;
   assign pc_inc     = pc + AW'(1);
   assign wd_expired = (wdog == WD_LAST);
   assign last_instr = (({1'b0, pc} + (AW+1)'(1)) == n_lat);

   // Decoded from the state register so that an async reset clears them
   // immediately.
   assign busy     = (state != S_IDLE);
   assign done     = (state == S_FINISH);
   assign cpu_load = (state == S_LOAD);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic. In the three waiting states the cpu response wins over
   // an expiring watchdog in the same cycle.
   always_comb begin
      state_nx = state;
      wd_abort = 1'b0;
      case (state)
         S_IDLE: begin
            if (go) begin
               state_nx = (n_sat == '0) ? S_FINISH : S_LOAD;
            end
         end
         S_LOAD: begin
            state_nx = S_STROBE;
         end
         S_STROBE: begin
            if (cpu_w) begin
               state_nx = S_ACK;
            end else if (wd_expired) begin
               state_nx = S_IDLE;
               wd_abort = 1'b1;
            end
         end
         S_ACK: begin
            if (!cpu_w) begin
               state_nx = S_RUN;
            end else if (wd_expired) begin
               state_nx = S_IDLE;
               wd_abort = 1'b1;
            end
         end
         S_RUN: begin
            if (cpu_w) begin
               state_nx = S_CAPTURE;
            end else if (wd_expired) begin
               state_nx = S_IDLE;
               wd_abort = 1'b1;
            end
         end
         S_CAPTURE: begin
            state_nx = last_instr ? S_FINISH : S_LOAD;
         end
         S_FINISH: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Watchdog: cycles spent in the current state. It restarts on every state
   // change, so a stuck wait state aborts after exactly TIMEOUT_CYC cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wdog <= '0;
      end else if (state_nx != state) begin
         wdog <= '0;
      end else if (!wd_expired) begin
         wdog <= wdog + WDW'(1);
      end
   end

   // Program memory has no reset; writes are only accepted while idle.
   always_ff @(posedge clk) begin
      if (prog_we && (state == S_IDLE)) begin
         mem[prog_addr] <= prog_wdata;
      end
   end

   // Sequencer datapath. cpu_in is updated on the way into LOAD so the word is
   // already stable during the cycle in which cpu_load is high, and it is then
   // held until the next LOAD.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cpu_in     <= '0;
         cpu_s      <= 1'b0;
         pc         <= '0;
         n_lat      <= '0;
         timeout    <= 1'b0;
         last_out   <= '0;
         last_flags <= '0;
      end else begin
         if (wd_abort) begin
            timeout <= 1'b1;
            cpu_s   <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               if (go) begin
                  timeout <= 1'b0;
                  n_lat   <= n_sat;
                  if (n_sat != '0) begin
                     pc     <= '0;
                     cpu_in <= mem[0];
                  end
               end
            end
            S_STROBE: begin
               if (cpu_w) begin
                  cpu_s <= 1'b1;
               end
            end
            S_ACK: begin
               if (!cpu_w) begin
                  cpu_s <= 1'b0;
               end
            end
            S_CAPTURE: begin
               last_out   <= cpu_out;
               last_flags <= {cpu_N, cpu_V, cpu_Z};
               if (!last_instr) begin
                  pc     <= pc_inc;
                  cpu_in <= mem[pc_inc];
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef FEEDER_CHECK_EN
   logic [15:0] exp_mem [DEPTH];

   // Expected-result memory shares the program address; idle-only writes.
   always_ff @(posedge clk) begin
      if (exp_we && (state == S_IDLE)) begin
         exp_mem[prog_addr] <= exp_wdata;
      end
   end

   // Only the first difference of a sequence is recorded.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mismatch    <= 1'b0;
         mismatch_pc <= '0;
      end else if ((state == S_IDLE) && go) begin
         mismatch <= 1'b0;
      end else if ((state == S_CAPTURE) && !mismatch && (cpu_out != exp_mem[pc])) begin
         mismatch    <= 1'b1;
         mismatch_pc <= pc;
      end
   end
`endif

endmodule
